ad9252_frame_packer: RTL and testbench

- Sits after the per-channel ADC deserialisers in the frame-clock domain.
- Qualifies alignment of a run-time-selectable channel subset, gates acquisition with a lock/run state machine, and applies programmable decimation.
- Packs all enabled channel words plus a 16-bit frame sequence number into one external-FIFO word.
- Counts frames dropped on FIFO full and realignment events. Replaces the fixed 4-channel AND-of-aligned and ungated write enable used today.

---
 rtl/ad9252_frame_packer.sv | 177 +++++++++++++++++
 tb/tb_ad9252_frame_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9252_frame_packer.sv
// Frame packer for AD9252 deserialised channels: alignment qualification, lock/run FSM, decimation, FIFO packing.
// Optional per-channel test-pattern checker enabled by defining AD9252_PACKER_PATTERN_CHK_EN.
module ad9252_frame_packer #(
   parameter int ADC_CHANEL  = 8,
   parameter int DATA_WIDTH  = 14,
   parameter int LOCK_FRAMES = 16,
   parameter int SEQ_WIDTH   = 16
) (
   input  logic                                     ad_dco_fc,
   input  logic                                     reset_n,
   input  logic [ADC_CHANEL-1:0]                    ch_aligned,
   input  logic [ADC_CHANEL*DATA_WIDTH-1:0]         ch_data,
   input  logic [ADC_CHANEL-1:0]                    ch_mask,
   input  logic                                     soft_start,
   input  logic [7:0]                               decim,
   input  logic                                     data_fifo_full,
`ifdef AD9252_PACKER_PATTERN_CHK_EN
   input  logic [DATA_WIDTH-1:0]                    chk_pattern,
   output logic [ADC_CHANEL-1:0]                    pattern_err,
   output logic [15:0]                              err_cnt,
`endif
   output logic                                     data_fifo_wren,
   output logic [SEQ_WIDTH+ADC_CHANEL*DATA_WIDTH-1:0] data_fifo_din,
   output logic                                     data_aligned,
   output logic [2:0]                               state_o,
   output logic [15:0]                              drop_cnt,
   output logic [7:0]                               realign_cnt,
   output logic                                     overflow
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_ALIGN = 3'd1;
   localparam logic [2:0] ST_LOCK       = 3'd2;
   localparam logic [2:0] ST_RUN        = 3'd3;
   localparam logic [2:0] ST_PAUSE      = 3'd4;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [7:0]           lock_cnt;
   logic [7:0]           dcnt;
   logic [SEQ_WIDTH-1:0] seq;
   logic                 qual;
   logic                 run_hold;
   logic                 frame_due;
   logic                 start_acq;
   logic                 enter_run;

   // An empty mask must never qualify, otherwise acquisition would start with no channels.
   assign qual      = (|ch_mask) & (&(ch_aligned | ~ch_mask));
   assign run_hold  = (state == ST_RUN) & data_aligned & soft_start;
   assign frame_due = run_hold & (dcnt == 8'd0);
   assign start_acq = (state == ST_IDLE) & soft_start;
   assign enter_run = (state_nxt == ST_RUN) & (state != ST_RUN);
   assign state_o   = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (soft_start) state_nxt = ST_WAIT_ALIGN;
         end
         ST_WAIT_ALIGN: begin
            if (!soft_start)       state_nxt = ST_IDLE;
            else if (data_aligned) state_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            if (!soft_start)              state_nxt = ST_IDLE;
            else if (!data_aligned)       state_nxt = ST_WAIT_ALIGN;
            else if (lock_cnt == LOCK_LAST) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!data_aligned)    state_nxt = ST_WAIT_ALIGN;
            else if (!soft_start) state_nxt = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (!data_aligned)    state_nxt = ST_WAIT_ALIGN;
            else if (soft_start)  state_nxt = ST_RUN;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         data_aligned <= 1'b0;
         lock_cnt     <= 8'd0;
      end else begin
         state        <= state_nxt;
         data_aligned <= qual;
         if (state == ST_WAIT_ALIGN)
            lock_cnt <= 8'd0;
         else if ((state == ST_LOCK) && data_aligned && (lock_cnt != LOCK_LAST))
            lock_cnt <= lock_cnt + 8'd1;
      end
   end

   // A decim lowered below the running count wraps immediately rather than counting up to 255.
   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         dcnt <= 8'd0;
      end else if (enter_run) begin
         dcnt <= 8'd0;
      end else if (run_hold) begin
         dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
      end
   end

   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         seq            <= '0;
         data_fifo_wren <= 1'b0;
         data_fifo_din  <= '0;
      end else begin
         data_fifo_wren <= frame_due & ~data_fifo_full;
         if (frame_due && !data_fifo_full)
            data_fifo_din <= {seq, ch_data};
         // Dropped frames still consume a sequence number so the consumer can see the gap.
         if ((state == ST_LOCK) && enter_run)
            seq <= '0;
         else if (frame_due)
            seq <= seq + 1'b1;
      end
   end

   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= 16'd0;
         overflow <= 1'b0;
      end else if (start_acq) begin
         drop_cnt <= 16'd0;
         overflow <= 1'b0;
      end else if (frame_due && data_fifo_full) begin
         overflow <= 1'b1;
         if (drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         realign_cnt <= 8'd0;
      end else if ((state == ST_RUN) && !data_aligned && (realign_cnt != 8'hFF)) begin
         realign_cnt <= realign_cnt + 8'd1;
      end
   end

`ifdef AD9252_PACKER_PATTERN_CHK_EN
   logic [ADC_CHANEL-1:0] mism;
   logic                  chk_active;

   assign chk_active = (state == ST_LOCK) | (state == ST_RUN);

   always_comb begin
      mism = '0;
      for (int c = 0; c < ADC_CHANEL; c++)
         mism[c] = ch_mask[c] & (ch_data[c*DATA_WIDTH +: DATA_WIDTH] != chk_pattern);
   end

   always_ff @(posedge ad_dco_fc or negedge reset_n) begin
      if (!reset_n) begin
         pattern_err <= '0;
         err_cnt     <= 16'd0;
      end else if (start_acq) begin
         pattern_err <= '0;
         err_cnt     <= 16'd0;
      end else if (chk_active) begin
         pattern_err <= pattern_err | mism;
         if ((|mism) && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ad9252_frame_packer.sv
// Self-checking bench for ad9252_frame_packer with a frame-level write model and randomized data/full stimulus.
// Pattern-checker scenario is built only when AD9252_PACKER_PATTERN_CHK_EN is defined.
module tb_ad9252_frame_packer;

   localparam int NCH = 8;
   localparam int DW  = 14;
   localparam int CW  = NCH * DW;
   localparam int OW  = 16 + CW;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NCH-1:0]  ch_aligned;
   logic [CW-1:0]   ch_data;
   logic [NCH-1:0]  ch_mask;
   logic            soft_start;
   logic [7:0]      decim;
   logic            data_fifo_full;
   logic            data_fifo_wren;
   logic [OW-1:0]   data_fifo_din;
   logic            data_aligned;
   logic [2:0]      state_o;
   logic [15:0]     drop_cnt;
   logic [7:0]      realign_cnt;
   logic            overflow;
`ifdef AD9252_PACKER_PATTERN_CHK_EN
   logic [DW-1:0]   chk_pattern = 14'h2A5A;
   logic [NCH-1:0]  pattern_err;
   logic [15:0]     err_cnt;
`endif

   int          total = 0;
   int          bad = 0;
   // Model state: frames counted since the decimation phase was last known to be zero.
   int          k;
   int          base;
   logic [15:0] m_seq;
   int          m_drop;

   always #5 clk = ~clk;

   ad9252_frame_packer dut (
      .ad_dco_fc      (clk),
      .reset_n        (reset_n),
      .ch_aligned     (ch_aligned),
      .ch_data        (ch_data),
      .ch_mask        (ch_mask),
      .soft_start     (soft_start),
      .decim          (decim),
      .data_fifo_full (data_fifo_full),
`ifdef AD9252_PACKER_PATTERN_CHK_EN
      .chk_pattern    (chk_pattern),
      .pattern_err    (pattern_err),
      .err_cnt        (err_cnt),
`endif
      .data_fifo_wren (data_fifo_wren),
      .data_fifo_din  (data_fifo_din),
      .data_aligned   (data_aligned),
      .state_o        (state_o),
      .drop_cnt       (drop_cnt),
      .realign_cnt    (realign_cnt),
      .overflow       (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n        = 1'b0;
      soft_start     = 1'b0;
      ch_mask        = 8'hFF;
      ch_aligned     = 8'hFF;
      decim          = 8'd0;
      data_fifo_full = 1'b0;
      ch_data        = '0;
      tick();
      tick();
      reset_n = 1'b1;
      m_seq   = 16'd0;
      m_drop  = 0;
      k       = 0;
      base    = 0;
   endtask

   // Drives n RUN frames of random data; a frame is due every decim+1 frames counted from base.
   task automatic run_seg(input int n, input int full_pct);
      logic [CW-1:0] d;
      logic          f;
      logic          due;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < NCH; c++) d[c*DW +: DW] = 14'($urandom);
         f   = ($urandom_range(0, 99) < full_pct);
         due = (k >= base) && (((k - base) % (int'(decim) + 1)) == 0);
         ch_data        = d;
         data_fifo_full = f;
         tick();
         total++;
         if (due && !f) begin
            if (data_fifo_wren !== 1'b1 || data_fifo_din !== {m_seq, d}) begin
               bad++;
               $display("FAIL write k=%0d wren=%b din=%h expected din=%h", k, data_fifo_wren, data_fifo_din, {m_seq, d});
            end
         end else if (data_fifo_wren !== 1'b0) begin
            bad++;
            $display("FAIL no_write k=%0d wren=%b expected 0", k, data_fifo_wren);
         end
         if (due) begin
            m_seq = m_seq + 16'd1;
            if (f && m_drop < 65535) m_drop++;
         end
         k++;
      end
      data_fifo_full = 1'b0;
   endtask

   task automatic enter_run();
      int n;
      n = 0;
      while (state_o !== 3'd3 && n < 100) begin
         tick();
         n++;
      end
      total++;
      if (state_o !== 3'd3) begin
         bad++;
         $display("FAIL enter_run state=%0d expected 3 within 100 cycles", state_o);
      end
      k = 0;
      base = 0;
      m_seq = 16'd0;
   endtask

   task automatic test_reset();
      do_reset();
      total += 4;
      if (state_o !== 3'd0 || data_aligned !== 1'b0) begin
         bad++; $display("FAIL reset_state state=%0d aligned=%b expected 0/0", state_o, data_aligned);
      end
      if (data_fifo_wren !== 1'b0 || data_fifo_din !== '0) begin
         bad++; $display("FAIL reset_write wren=%b din=%h expected 0", data_fifo_wren, data_fifo_din);
      end
      if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL reset_drop drop=%0d ovf=%b expected 0", drop_cnt, overflow);
      end
      if (realign_cnt !== 8'd0) begin
         bad++; $display("FAIL reset_realign realign=%0d expected 0", realign_cnt);
      end
   endtask

   task automatic test_bringup();
      logic [2:0] exp_st;
      soft_start = 1'b1;
      tick();
      total++;
      if (state_o !== 3'd1 || data_aligned !== 1'b1) begin
         bad++; $display("FAIL bringup_edge1 state=%0d aligned=%b expected 1/1", state_o, data_aligned);
      end
      for (int e = 2; e <= 18; e++) begin
         tick();
         exp_st = (e < 18) ? 3'd2 : 3'd3;
         total++;
         if (state_o !== exp_st || data_fifo_wren !== 1'b0) begin
            bad++; $display("FAIL bringup edge=%0d state=%0d wren=%b expected %0d/0", e, state_o, data_fifo_wren, exp_st);
         end
      end
      k = 0; base = 0; m_seq = 16'd0;
   endtask

   task automatic test_seq_decim0();
      run_seg(10, 0);
   endtask

   task automatic test_decim();
      decim = 8'd3;
      base  = k;
      run_seg(6, 0);
      // Next frame runs with the count at 2; lowering decim to 1 wraps it, so writes resume one frame later.
      decim = 8'd1;
      base  = k + 1;
      run_seg(7, 0);
      decim = 8'd0;
      base  = k;
   endtask

   task automatic test_full();
      run_seg(5, 100);
      total += 2;
      if (drop_cnt !== 16'd5) begin
         bad++; $display("FAIL full_drop drop=%0d expected 5", drop_cnt);
      end
      if (overflow !== 1'b1) begin
         bad++; $display("FAIL full_ovf ovf=%b expected 1", overflow);
      end
      run_seg(3, 0);
      for (int s = 0; s < 4; s++) begin
         int l;
         decim = 8'($urandom_range(0, 3));
         base  = k;
         l     = $urandom_range(3, 8);
         run_seg(l * (int'(decim) + 1), 40);
      end
      decim = 8'd0;
      base  = k;
      total++;
      if (drop_cnt !== 16'(m_drop) || overflow !== (m_drop != 0)) begin
         bad++; $display("FAIL random_drop drop=%0d ovf=%b expected %0d", drop_cnt, overflow, m_drop);
      end
   endtask

   task automatic test_realign();
      ch_aligned[6] = 1'b0;
      run_seg(1, 0);
      tick();
      total++;
      if (state_o !== 3'd1 || data_fifo_wren !== 1'b0 || realign_cnt !== 8'd1 || drop_cnt !== 16'(m_drop)) begin
         bad++; $display("FAIL realign_exit state=%0d wren=%b realign=%0d drop=%0d expected 1/0/1/%0d",
                         state_o, data_fifo_wren, realign_cnt, drop_cnt, m_drop);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (state_o !== 3'd1 || data_fifo_wren !== 1'b0) begin
            bad++; $display("FAIL realign_hold state=%0d wren=%b expected 1/0", state_o, data_fifo_wren);
         end
      end
      soft_start = 1'b0;
      tick();
      total++;
      if (state_o !== 3'd0 || drop_cnt !== 16'(m_drop)) begin
         bad++; $display("FAIL to_idle state=%0d drop=%0d expected 0/%0d", state_o, drop_cnt, m_drop);
      end
      soft_start = 1'b1;
      tick();
      m_drop = 0;
      total++;
      if (state_o !== 3'd1 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL restart_clear state=%0d drop=%0d ovf=%b expected 1/0/0", state_o, drop_cnt, overflow);
      end
      ch_aligned[6] = 1'b1;
      enter_run();
      run_seg(4, 0);
      ch_mask[6]    = 1'b0;
      ch_aligned[6] = 1'b0;
      run_seg(6, 0);
      total++;
      if (state_o !== 3'd3 || realign_cnt !== 8'd1) begin
         bad++; $display("FAIL masked_loss state=%0d realign=%0d expected 3/1", state_o, realign_cnt);
      end
      ch_aligned = 8'hFF;
      ch_mask    = 8'hFF;
   endtask

   task automatic test_pause();
      decim = 8'd2;
      base  = k;
      run_seg(4, 0);
      soft_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (state_o !== 3'd4 || data_fifo_wren !== 1'b0) begin
            bad++; $display("FAIL pause state=%0d wren=%b expected 4/0", state_o, data_fifo_wren);
         end
      end
      soft_start = 1'b1;
      tick();
      total++;
      if (state_o !== 3'd3 || data_fifo_wren !== 1'b0) begin
         bad++; $display("FAIL resume state=%0d wren=%b expected 3/0", state_o, data_fifo_wren);
      end
      k = 0;
      base = 0;
      run_seg(6, 0);
   endtask

   task automatic test_async_reset();
      decim = 8'd0;
      base  = k;
      run_seg(1, 0);
      #2;
      reset_n = 1'b0;
      #1;
      total += 2;
      if (data_fifo_wren !== 1'b0 || state_o !== 3'd0 || data_fifo_din !== '0) begin
         bad++; $display("FAIL async_reset wren=%b state=%0d expected 0/0", data_fifo_wren, state_o);
      end
      if (drop_cnt !== 16'd0 || realign_cnt !== 8'd0 || overflow !== 1'b0 || data_aligned !== 1'b0) begin
         bad++; $display("FAIL async_reset_cnt drop=%0d realign=%0d ovf=%b expected 0", drop_cnt, realign_cnt, overflow);
      end
      ch_mask    = 8'h00;
      soft_start = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         total++;
         if (state_o !== 3'd1 || data_fifo_wren !== 1'b0 || data_aligned !== 1'b0) begin
            bad++; $display("FAIL empty_mask cyc=%0d state=%0d wren=%b expected 1/0", i, state_o, data_fifo_wren);
         end
      end
   endtask

`ifdef AD9252_PACKER_PATTERN_CHK_EN
   task automatic test_pattern();
      logic [CW-1:0] good;
      do_reset();
      for (int c = 0; c < NCH; c++) good[c*DW +: DW] = chk_pattern;
      ch_data    = good;
      soft_start = 1'b1;
      enter_run();
      for (int i = 0; i < 3; i++) begin
         ch_data = good;
         ch_data[2*DW +: DW] = chk_pattern ^ 14'($urandom_range(1, 16383));
         tick();
      end
      ch_data = good;
      tick();
      total++;
      if (pattern_err !== 8'h04 || err_cnt !== 16'd3) begin
         bad++; $display("FAIL pattern err=%h cnt=%0d expected 04/3", pattern_err, err_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bringup();
      test_seq_decim0();
      test_decim();
      test_full();
      test_realign();
      test_pause();
      test_async_reset();
`ifdef AD9252_PACKER_PATTERN_CHK_EN
      test_pattern();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
